move_ctrl_seq: RTL

- Control sequencer that drives the Datapath control inputs.
- Executes instruction fetch followed by the move-from-special-register group: mfhi, mflo, nop and halt.
- Replaces hand-written per-instruction benches as the initiator of the Datapath control interface.
- Sits beside Datapath. It consumes the IR contents and emits the one-hot bus-drive and register-load strobes.

---
 rtl/move_ctrl_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/move_ctrl_seq.sv
// Control sequencer for the Datapath: fetch in T0-T2, then mfhi/mflo/nop/halt in T3.
// Every control output is a flop loaded from the decode of the next state.
module move_ctrl_seq #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Stop,
    input  logic [31:0]      IR,
    output logic             IncPC,
    output logic             Read,
    output logic             PC_Out,
    output logic             MDR_Out,
    output logic             HI_Out,
    output logic             LO_Out,
    output logic             PC_In,
    output logic             MDR_In,
    output logic             MAR_In,
    output logic             IR_In,
    output logic             G_RA,
    output logic             R_In,
    output logic             Run,
    output logic             Illegal_Op,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] Instr_Count
);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    typedef struct packed {
        logic inc_pc;
        logic read;
        logic pc_out;
        logic mdr_out;
        logic hi_out;
        logic lo_out;
        logic pc_in;
        logic mdr_in;
        logic mar_in;
        logic ir_in;
        logic g_ra;
        logic r_in;
    } ctrl_t;

    localparam logic [4:0] OP_MFHI   = 5'b10111;
    localparam logic [4:0] OP_MFLO   = 5'b11000;
    localparam logic [4:0] OP_NOP    = 5'b11010;
    localparam logic [4:0] OP_HALT   = 5'b11011;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [4:0]       op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             run_q, run_d;
    logic             illegal_q, illegal_d;
    logic             unused_ir;

    assign unused_ir = ^IR[26:0];

    // The opcode is captured on T3 entry so the T3 strobes and the halt decision agree.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        op_d    = op_q;
        count_d = count_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0: begin
                state_d = ST_T1;
                wait_d  = '0;
            end
            ST_T1: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_T2;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_T2: begin
                state_d = ST_T3;
                op_d    = IR[31:27];
            end
            ST_T3: begin
                count_d = count_q + CNT_W'(1);
                if (op_q == OP_HALT || Stop) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        run_d     = (state_d == ST_T0) || (state_d == ST_T1) ||
                    (state_d == ST_T2) || (state_d == ST_T3);
        case (state_d)
            ST_T0: begin
                ctrl_d.pc_out = 1'b1;
                ctrl_d.mar_in = 1'b1;
                ctrl_d.inc_pc = 1'b1;
            end
            ST_T1: begin
                ctrl_d.read   = 1'b1;
                ctrl_d.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (op_d)
                    OP_MFHI: begin
                        ctrl_d.g_ra   = 1'b1;
                        ctrl_d.r_in   = 1'b1;
                        ctrl_d.hi_out = 1'b1;
                    end
                    OP_MFLO: begin
                        ctrl_d.g_ra   = 1'b1;
                        ctrl_d.r_in   = 1'b1;
                        ctrl_d.lo_out = 1'b1;
                    end
                    OP_NOP, OP_HALT: ;
                    default: illegal_d = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q   <= ST_RST;
            wait_q    <= '0;
            op_q      <= '0;
            count_q   <= '0;
            ctrl_q    <= '0;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            op_q      <= op_d;
            count_q   <= count_d;
            ctrl_q    <= ctrl_d;
            run_q     <= run_d;
            illegal_q <= illegal_d;
        end
    end

    assign IncPC       = ctrl_q.inc_pc;
    assign Read        = ctrl_q.read;
    assign PC_Out      = ctrl_q.pc_out;
    assign MDR_Out     = ctrl_q.mdr_out;
    assign HI_Out      = ctrl_q.hi_out;
    assign LO_Out      = ctrl_q.lo_out;
    assign PC_In       = ctrl_q.pc_in;
    assign MDR_In      = ctrl_q.mdr_in;
    assign MAR_In      = ctrl_q.mar_in;
    assign IR_In       = ctrl_q.ir_in;
    assign G_RA        = ctrl_q.g_ra;
    assign R_In        = ctrl_q.r_in;
    assign Run         = run_q;
    assign Illegal_Op  = illegal_q;
    assign State       = state_q;
    assign Instr_Count = count_q;

endmodule
